// File: rtl/clap_event_detector.sv
// Turns the FIR filter's sample stream into single-cycle clap events and a saturating clap count.
// Latency: clap_pulse and double_clap rise one clock after the qualifying valid sample; every output is registered.
// Backpressure: none. Samples are accepted on every cycle with sample_valid set, and idle cycles freeze all state.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   sample_in    filtered sample, unsigned magnitude, DW bits
//   sample_valid sample_in is valid this cycle; envelope, FSM and counters advance only on valid
//   count_clr    synchronous clear of clap_count; it wins over a simultaneous clap
//   clap_pulse   one-cycle pulse for each detected clap
//   double_clap  one-cycle pulse when a clap lands inside the window opened by the previous clap
//   clap_count   number of claps since reset or clear, saturating at 255
//   busy         high while the detector is ARMED or in REFRACT
//   envelope     current peak-hold/decay envelope
//
// Optional feature: define CLAP_DOUBLE_EN to build the double-clap window. Without it, double_clap is tied low.
module clap_event_detector #(
  parameter int DW          = 10,
  parameter int THRESH      = 300,
  parameter int MIN_LEN     = 2,
  parameter int REFRACT     = 64,
  parameter int DECAY_SHIFT = 3,
  parameter int WINDOW      = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  input  logic          count_clr,
  output logic          clap_pulse,
  output logic          double_clap,
  output logic [7:0]    clap_count,
  output logic          busy,
  output logic [DW-1:0] envelope
);

  localparam int RUN_W  = $clog2(MIN_LEN + 1);
  localparam int RCNT_W = $clog2(REFRACT + 1);
  localparam logic [DW-1:0] THRESH_V = DW'(THRESH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_REFRACT = 2'd2
  } state_t;

  state_t            state;
  logic [RUN_W-1:0]  run;
  logic [RCNT_W-1:0] rcnt;
  logic [DW-1:0]     env;
  logic [DW-1:0]     env_dec;
  logic [DW-1:0]     env_nxt;
  logic              loud;
  logic              fire;

  // The decayed value never exceeds env, so the subtraction cannot wrap.
  always_comb begin
    env_dec = env - (env >> DECAY_SHIFT);
    env_nxt = (sample_in > env_dec) ? sample_in : env_dec;
    loud    = (env_nxt >= THRESH_V);
  end

  // fire marks the valid sample that completes a run of MIN_LEN loud samples.
  always_comb begin
    fire = 1'b0;
    if (sample_valid && loud) begin
      if (state == S_IDLE) begin
        fire = (MIN_LEN == 1);
      end else if (state == S_ARMED) begin
        fire = (run == RUN_W'(MIN_LEN - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      run        <= '0;
      rcnt       <= '0;
      env        <= '0;
      busy       <= 1'b0;
      clap_pulse <= 1'b0;
    end else begin
      clap_pulse <= fire;
      if (sample_valid) begin
        env <= env_nxt;
        case (state)
          S_IDLE: begin
            if (loud) begin
              run  <= RUN_W'(1);
              busy <= 1'b1;
              if (fire) begin
                rcnt  <= '0;
                state <= S_REFRACT;
              end else begin
                state <= S_ARMED;
              end
            end
          end
          S_ARMED: begin
            if (loud) begin
              run <= run + RUN_W'(1);
              if (fire) begin
                rcnt  <= '0;
                state <= S_REFRACT;
              end
            end else begin
              run   <= '0;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          S_REFRACT: begin
            // Loudness is ignored here. A burst that is still loud after this must re-qualify from IDLE.
            if (rcnt == RCNT_W'(REFRACT - 1)) begin
              rcnt  <= '0;
              run   <= '0;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              rcnt <= rcnt + RCNT_W'(1);
            end
          end
          default: begin
            run   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clap_count <= '0;
    end else if (count_clr) begin
      clap_count <= '0;
    end else if (fire && (clap_count != 8'hFF)) begin
      clap_count <= clap_count + 8'd1;
    end
  end

  assign envelope = env;

`ifdef CLAP_DOUBLE_EN
  localparam int WCNT_W = $clog2(WINDOW + 1);

  logic              win;
  logic [WCNT_W-1:0] wcnt;

  // A clap opens the window. A clap arriving while the window is open pairs with it and closes it,
  // so the clap after that one starts a fresh window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win         <= 1'b0;
      wcnt        <= '0;
      double_clap <= 1'b0;
    end else begin
      double_clap <= 1'b0;
      if (fire) begin
        wcnt <= '0;
        if (win && (wcnt < WCNT_W'(WINDOW))) begin
          double_clap <= 1'b1;
          win         <= 1'b0;
        end else begin
          win <= 1'b1;
        end
      end else if (sample_valid && win) begin
        // The window expires silently when the count reaches WINDOW.
        if (wcnt == WCNT_W'(WINDOW - 1)) begin
          win  <= 1'b0;
          wcnt <= '0;
        end else begin
          wcnt <= wcnt + WCNT_W'(1);
        end
      end
    end
  end
`else
  assign double_clap = 1'b0;
`endif

endmodule

// File: tb/tb_clap_event_detector.sv
module tb_clap_event_detector;

  localparam int REFR = 8;
  localparam int WIN  = 32;

  logic       clk;
  logic       rst;
  logic [9:0] sample_in;
  logic       sample_valid;
  logic       count_clr;
  logic       clap_pulse;
  logic       double_clap;
  logic [7:0] clap_count;
  logic       busy;
  logic [9:0] envelope;

  clap_event_detector #(.REFRACT(REFR), .WINDOW(WIN)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .count_clr    (count_clr),
    .clap_pulse   (clap_pulse),
    .double_clap  (double_clap),
    .clap_count   (clap_count),
    .busy         (busy),
    .envelope     (envelope)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pulse;
    int dbl;
    int cnt;
    int bsy;
    int env;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_err = 0;
  int n_pulse = 0;
  int n_dbl = 0;

`ifdef CLAP_DOUBLE_EN
  localparam int DBL_ON = 1;
`else
  localparam int DBL_ON = 0;
`endif

  // Reference model state: 0 idle, 1 armed, 2 refractory.
  int m_env, m_state, m_run, m_rcnt, m_cnt, m_wcnt;
  bit m_win;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_env = 0; m_state = 0; m_run = 0; m_rcnt = 0; m_cnt = 0; m_wcnt = 0; m_win = 0;
  endtask

  // Drive one cycle of stimulus. The model predicts the outputs for the following edge
  // and pushes them, and those outputs are popped and compared after the edge.
  task automatic step(input bit v, input int s, input bit clr);
    exp_t e;
    int dec, nxt;
    bit loud, fire;
    exp_t got;
    sample_valid = v;
    sample_in    = s[9:0];
    count_clr    = clr;
    fire = 0;
    if (v) begin
      dec   = m_env - (m_env >> 3);
      nxt   = (s > dec) ? s : dec;
      loud  = (nxt >= 300);
      m_env = nxt;
      if (m_state == 2) begin
        m_rcnt++;
        if (m_rcnt == REFR) begin m_state = 0; m_run = 0; end
      end else if (loud) begin
        m_run++;
        if (m_run >= 2) begin fire = 1; m_state = 2; m_rcnt = 0; end
        else m_state = 1;
      end else begin
        m_run = 0; m_state = 0;
      end
    end
    e.dbl = 0;
    if (DBL_ON == 1) begin
      if (fire) begin
        if (m_win) begin e.dbl = 1; m_win = 0; end
        else begin m_win = 1; m_wcnt = 0; end
      end else if (v && m_win) begin
        m_wcnt++;
        if (m_wcnt == WIN) m_win = 0;
      end
    end
    if (clr) m_cnt = 0;
    else if (fire && m_cnt < 255) m_cnt++;
    e.pulse = fire;
    e.cnt   = m_cnt;
    e.bsy   = (m_state != 0);
    e.env   = m_env;
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    chk("pulse", clap_pulse, got.pulse);
    chk("double", double_clap, got.dbl);
    chk("count", clap_count, got.cnt);
    chk("busy", busy, got.bsy);
    chk("envelope", envelope, got.env);
    n_pulse += clap_pulse;
    n_dbl   += double_clap;
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask

  // Two loud samples (one clap), then zeros so that claps repeat every 'period' samples.
  task automatic clap(input int period);
    step(1, 400, 0);
    step(1, 400, 0);
    zeros(period - 2);
  endtask

  int p0, d0;

  initial begin
    rst = 1'b0; sample_valid = 1'b0; sample_in = '0; count_clr = 1'b0;
    model_reset();

    // Hold reset for two cycles, then release it and feed one zero sample.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 0, 0);
    chk("rst_pulse", clap_pulse, 0);
    chk("rst_dbl", double_clap, 0);
    chk("rst_count", clap_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_env", envelope, 0);

    // A single spike qualifies on its second (decayed) sample.
    p0 = n_pulse;
    step(1, 400, 0);
    chk("spike_env0", envelope, 400);
    chk("spike_nopulse_first", clap_pulse, 0);
    step(1, 0, 0);
    chk("spike_env1", envelope, 350);
    chk("spike_pulse", clap_pulse, 1);
    step(1, 0, 0);
    chk("spike_env2", envelope, 307);
    chk("spike_pulse_single", clap_pulse, 0);
    step(1, 0, 0);
    chk("spike_env3", envelope, 269);
    zeros(40);
    chk("spike_npulse", n_pulse - p0, 1);
    chk("spike_count", clap_count, 1);

    // A weaker spike decays below threshold before the run completes.
    p0 = n_pulse;
    step(1, 320, 0);
    chk("weak_env0", envelope, 320);
    step(1, 0, 0);
    chk("weak_env1", envelope, 280);
    zeros(40);
    chk("weak_npulse", n_pulse - p0, 0);

    // A second burst that falls inside the refractory period is ignored.
    p0 = n_pulse;
    step(1, 400, 0); step(1, 400, 0);
    zeros(3);
    step(1, 400, 0); step(1, 400, 0);
    zeros(40);
    chk("refract_one", n_pulse - p0, 1);

    // A second burst that arrives after the refractory period produces a second clap.
    p0 = n_pulse;
    step(1, 400, 0); step(1, 400, 0);
    zeros(10);
    step(1, 400, 0); step(1, 400, 0);
    zeros(40);
    chk("refract_two", n_pulse - p0, 2);

    // Double-clap window.
    d0 = n_dbl;
    clap(20); clap(20);
    chk("dbl_20", n_dbl - d0, DBL_ON);
    zeros(40);
    d0 = n_dbl;
    clap(40); clap(40);
    chk("dbl_40", n_dbl - d0, 0);
    d0 = n_dbl;
    clap(20);
    chk("dbl_three_1st", n_dbl - d0, 0);
    clap(20);
    chk("dbl_three_2nd", n_dbl - d0, DBL_ON);
    clap(20);
    chk("dbl_three_3rd", n_dbl - d0, DBL_ON);
    zeros(40);

    // The clap counter saturates at 255.
    for (int i = 0; i < 260; i++) clap(12);
    chk("count_sat", clap_count, 255);

    // A clear arriving together with a fire takes priority.
    zeros(40);
    step(1, 400, 0);
    step(1, 400, 1);
    chk("clr_fire_pulse", clap_pulse, 1);
    chk("clr_fire_count", clap_count, 0);
    zeros(40);
    clap(12);
    chk("count_after_clr", clap_count, 1);
    zeros(40);

    // An asynchronous reset while ARMED discards the event.
    p0 = n_pulse;
    step(1, 400, 0);
    chk("armed_busy", busy, 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_env", envelope, 0);
    chk("arst_count", clap_count, 0);
    #3;
    rst = 1'b1;
    step(0, 0, 0);
    chk("arst_idle_busy", busy, 0);
    zeros(12);
    chk("arst_npulse", n_pulse - p0, 0);

    // Gaps in sample_valid inside a burst do not break qualification.
    p0 = n_pulse;
    step(1, 400, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("gap_pulse", clap_pulse, 1);
    zeros(20);
    chk("gap_npulse", n_pulse - p0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
